// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes and FSM states.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_RMW_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: load extract/extend and store lane merge into a word.
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    ld_data_o = word_i;
    st_word_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        st_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ld_data_o = word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: sub-word loads/stores over a word-wide memory,
// with 2-cycle read-modify-write for SB/SH and fault detection on accept.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [29:0] addr_q, addr_d;
  logic        wb_valid_q, fault_q;
  logic [31:0] wb_data_q, fault_addr_q;

  logic        accept, is_mem, illegal, do_op;
  logic [31:0] ld_data, st_word;

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign is_mem    = req_load | req_store;

  assign illegal = (req_load & req_store)
                 | (req_size == SZ_RSVD)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                 | (req_addr >= 32'(MEM_BYTES));

  // Bubbles (neither load nor store) never fault and never touch memory.
  assign do_op = accept & is_mem & ~illegal;

  lsu_lane u_lane (
    .word_i    (mem_read_data),
    .off_i     (req_addr[1:0]),
    .size_i    (req_size),
    .signed_i  (req_signed),
    .wdata_i   (req_wdata),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d        = state_q;
    merge_d        = merge_q;
    addr_d         = addr_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = {req_addr[31:2], 2'b00};
    mem_write_data = '0;
    case (state_q)
      S_IDLE: begin
        if (do_op) begin
          if (req_load) begin
            mem_read = 1'b1;
          end else if (req_size == SZ_WORD) begin
            mem_write      = 1'b1;
            mem_write_data = st_word;
          end else begin
            // Read old word now; the merged word is written next cycle.
            mem_read = 1'b1;
            merge_d  = st_word;
            addr_d   = req_addr[31:2];
            state_d  = S_RMW_WRITE;
          end
        end
      end
      S_RMW_WRITE: begin
        mem_write      = 1'b1;
        mem_address    = {addr_q, 2'b00};
        mem_write_data = merge_q;
        state_d        = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      merge_q      <= '0;
      addr_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      merge_q    <= merge_d;
      addr_q     <= addr_d;
      wb_valid_q <= do_op & req_load;
      fault_q    <= accept & is_mem & illegal;
      if (do_op & req_load)
        wb_data_q <= ld_data;
      if (accept & is_mem & illegal)
        fault_addr_q <= req_addr;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed and random ops.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load, req_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;
  logic        wb_valid, fault;
  logic [31:0] wb_data, fault_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_wb = -10, cur_wb = -10;

  logic [31:0] dmem [0:255];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] wb_q[$];
  logic [31:0] flt_q[$];
  logic [63:0] st_q[$];

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  assign mem_read_data = dmem[mem_address[9:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) dmem[mem_address[9:2]] <= mem_write_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL rd_wr_overlap: mem_read and mem_write both high");
      end
      if (wb_valid) begin
        prev_wb = cur_wb;
        cur_wb  = cyc;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got %h expected none", wb_data);
        end else chk("wb_data", wb_data, wb_q.pop_front());
      end
      if (fault) begin
        if (flt_q.size() == 0) begin
          errors++;
          $display("FAIL fault_unexpected: got %h expected none", fault_addr);
        end else chk("fault_addr", fault_addr, flt_q.pop_front());
      end
      if (mem_write) begin
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got %h expected none", mem_write_data);
        end else begin
          logic [63:0] e;
          e = st_q.pop_front();
          chk("write_addr", mem_address, e[63:32]);
          chk("write_data", mem_write_data, e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] ref_word(input int a);
    ref_word = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Drive one op at a negedge, wait for acceptance, then record the expected outcome.
  task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit has_exp, input logic [31:0] exp, output int stalls);
    bit flt;
    int n, base;
    logic [31:0] v;
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    #1;
    stalls = 0;
    while (!req_ready && stalls < 20) begin
      @(negedge clk); #1; stalls++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready stuck at 0");
      return;
    end
    flt = (ld || st) && ((ld && st) || sz == 2'd3 || (sz == 2'd1 && a[0]) ||
                         (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'd1024);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (flt) begin
      flt_q.push_back(a);
      chk("no_mem_on_fault", {30'd0, mem_read, mem_write}, 32'd0);
    end else if (ld) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      wb_q.push_back(has_exp ? exp : v);
    end else if (st) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      base = int'(a) & ~3;
      st_q.push_back({32'(base), has_exp ? exp : ref_word(base)});
    end else begin
      chk("bubble_no_mem", {30'd0, mem_read, mem_write}, 32'd0);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // SW then LW, no stall
    issue(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF, s);
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, s);
    chk("lw_stall", s, 0);
    // SB read-modify-write stalls the next op exactly one cycle
    issue(0, 1, 2'd0, 0, 32'h12, 32'h55, 1, 32'hDE55BEEF, s);
    issue(1, 0, 2'd0, 0, 32'h12, 32'h0, 1, 32'h00000055, s);
    chk("sb_stall", s, 1);
    issue(1, 0, 2'd0, 1, 32'h13, 32'h0, 1, 32'hFFFFFFDE, s);
    // SH and half loads
    issue(0, 1, 2'd1, 0, 32'h10, 32'h8001, 1, 32'hDE558001, s);
    issue(1, 0, 2'd1, 1, 32'h10, 32'h0, 1, 32'hFFFF8001, s);
    chk("sh_stall", s, 1);
    issue(1, 0, 2'd1, 0, 32'h10, 32'h0, 1, 32'h00008001, s);
    // faults
    issue(1, 0, 2'd1, 1, 32'h11, 32'h0, 0, 32'h0, s);
    issue(1, 0, 2'd2, 0, 32'h12, 32'h0, 0, 32'h0, s);
    issue(1, 0, 2'd3, 0, 32'h10, 32'h0, 0, 32'h0, s);
    issue(1, 0, 2'd2, 0, 32'h400, 32'h0, 0, 32'h0, s);
    issue(1, 1, 2'd2, 0, 32'h14, 32'h0, 0, 32'h0, s);
    go_idle();
    repeat (2) @(negedge clk);

    // SB then reset during RMW_WRITE: the store is abandoned
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'd0;
    req_addr = 32'h20; req_wdata = 32'hAA;
    #1;
    chk("rmw_accept_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0;
    #1;
    chk("rst_rmw_write", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_rmw_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rmw_fault_addr", fault_addr, 32'd0);
    chk("rst_rmw_wb_data", wb_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rmw_abandoned_mem", dmem[8], 32'd0);

    // back-to-back loads
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 32'hDE558001, s);
    issue(1, 0, 2'd2, 0, 32'h14, 32'h0, 1, 32'h00000000, s);
    chk("b2b_stall", s, 0);
    go_idle();
    @(negedge clk); #3;
    chk("b2b_consecutive", 32'(cur_wb - prev_wb), 32'd1);

    // random traffic in a 64-byte window plus occasional illegal ops
    for (int k = 0; k < 400; k++) begin
      int op;
      bit ld, st, sg;
      logic [1:0] sz;
      logic [31:0] a;
      op = $urandom_range(0, 19);
      sz = 2'($urandom_range(0, 2));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      ld = (op < 9); st = (op >= 9 && op < 18);
      if (op == 18) begin ld = 1; st = $urandom_range(0, 1) == 1; end
      if ($urandom_range(0, 9) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 29) == 0) a = 32'd1024 + a;
      if ($urandom_range(0, 29) == 0) sz = 2'd3;
      issue(ld, st, sz, sg, a, $urandom, 0, 32'h0, s);
    end
    go_idle();
    repeat (4) @(negedge clk);
    #3;
    chk("wb_q_drained", wb_q.size(), 0);
    chk("flt_q_drained", flt_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
